// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 5x4 matrix keypad scanner with row synchroniser and debounce
// Emits one registered newkey pulse and keycode {col, row} per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [4:0] col,
  output logic       newkey,
  output logic [4:0] keycode
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_meta_q, row_meta_d;
  logic [3:0]      row_sync_q, row_sync_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [2:0]      col_idx_q, col_idx_d;
  logic [4:0]      col_q, col_d;
  logic [2:0]      cand_col_q, cand_col_d;
  logic [1:0]      cand_row_q, cand_row_d;
  logic [CW-1:0]   match_q, match_d;
  logic [CW-1:0]   rel_q, rel_d;
  logic            newkey_q, newkey_d;
  logic [4:0]      keycode_q, keycode_d;

  logic            strobe;
  logic [2:0]      zero_cnt;
  logic [1:0]      hit_row;
  logic            single;
  logic            none;
  logic            advance;
  logic [CW-1:0]   match_inc;
  logic [CW-1:0]   rel_inc;

  // Row sample classification on the synchronised returns
  always_comb begin
    zero_cnt = 3'd0;
    hit_row  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_sync_q[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        hit_row  = 2'(i);
      end
    end
    single = (zero_cnt == 3'd1);
    none   = (zero_cnt == 3'd0);
  end

  assign strobe    = (dwell_q == DWELL_LAST);
  assign match_inc = match_q + 1'b1;
  assign rel_inc   = rel_q + 1'b1;

  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    dwell_d    = strobe ? '0 : dwell_q + 1'b1;
    state_d    = state_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    match_d    = match_q;
    rel_d      = rel_q;
    newkey_d   = 1'b0;
    keycode_d  = keycode_q;
    advance    = 1'b0;

    if (strobe) begin
      case (state_q)
        ST_SCAN: begin
          if (single) begin
            cand_col_d = col_idx_q;
            cand_row_d = hit_row;
            if (DEBOUNCE == 1) begin
              state_d   = ST_HELD;
              match_d   = CNT_MAX;
              rel_d     = '0;
              newkey_d  = 1'b1;
              keycode_d = {col_idx_q, hit_row};
            end else begin
              state_d = ST_DEBOUNCE;
              match_d = CW'(1);
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (single && (hit_row == cand_row_q)) begin
            match_d = match_inc;
            if (match_inc >= CNT_MAX) begin
              state_d   = ST_HELD;
              match_d   = CNT_MAX;
              rel_d     = '0;
              newkey_d  = 1'b1;
              keycode_d = {cand_col_q, cand_row_q};
            end
          end else begin
            match_d = '0;
            state_d = ST_SCAN;
            advance = 1'b1;
          end
        end
        ST_HELD: begin
          // Only a run of empty samples releases; anything else restarts the run
          if (none) begin
            if (rel_inc >= CNT_MAX) begin
              state_d = ST_SCAN;
              rel_d   = '0;
              match_d = '0;
              advance = 1'b1;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: begin
          state_d = ST_SCAN;
          match_d = '0;
          rel_d   = '0;
        end
      endcase
    end

    col_idx_d = col_idx_q;
    if (advance) begin
      col_idx_d = (col_idx_q == 3'd4) ? 3'd0 : col_idx_q + 3'd1;
    end
    col_d = ~(5'b00001 << col_idx_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SCAN;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      dwell_q    <= '0;
      col_idx_q  <= 3'd0;
      col_q      <= 5'b11110;
      cand_col_q <= 3'd0;
      cand_row_q <= 2'd0;
      match_q    <= '0;
      rel_q      <= '0;
      newkey_q   <= 1'b0;
      keycode_q  <= 5'd0;
    end else begin
      state_q    <= state_d;
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      newkey_q   <= newkey_d;
      keycode_q  <= keycode_d;
    end
  end

  assign col     = col_q;
  assign newkey  = newkey_q;
  assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3)
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [4:0]  col;
  logic        newkey;
  logic [4:0]  keycode;
  logic [19:0] keys;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int wide   = 0;
  int cyc    = 0;
  logic [1:0] phase;
  logic prev_nk = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .row    (row),
    .col    (col),
    .newkey (newkey),
    .keycode(keycode)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Switch matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  // Dwell phase used only to align stimulus with sample strobes
  always @(posedge clock or negedge reset) begin
    if (!reset) phase <= 2'd0;
    else        phase <= phase + 2'd1;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (newkey === 1'b1) begin
      pulses = pulses + 1;
      if (prev_nk) wide = wide + 1;
    end
    prev_nk = (newkey === 1'b1);
  end

  typedef struct {
    logic [19:0] keys;
    logic [4:0]  exp_col;
    logic        exp_newkey;
  } vec_t;

  vec_t       vecs[20];
  logic [4:0] colpat[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_strobe_col(input logic [4:0] c, input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(phase == 2'd3 && col == c) && n < 200);
    chk(nm, {31'd0, (phase == 2'd3 && col == c)}, 32'd1);
  endtask

  task automatic wait_pulses(input int target, input string nm);
    int n;
    n = 0;
    while (pulses < target && n < 300) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, pulses >= target}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t1;
    int t2;

    colpat[0] = 5'b11110;
    colpat[1] = 5'b11101;
    colpat[2] = 5'b11011;
    colpat[3] = 5'b10111;
    colpat[4] = 5'b01111;
    for (int i = 0; i < 20; i++) begin
      vecs[i].keys       = 20'd0;
      vecs[i].exp_col    = colpat[i/4];
      vecs[i].exp_newkey = 1'b0;
    end

    keys  = 20'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    chk("rst_col", col, 5'b11110);
    chk("rst_newkey", newkey, 0);
    chk("rst_keycode", keycode, 0);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      keys = vecs[i].keys;
      chk($sformatf("scan_col[%0d]", i), col, vecs[i].exp_col);
      chk($sformatf("scan_nk[%0d]", i), newkey, vecs[i].exp_newkey);
      tick();
    end

    // Clean press col 2 / row 1, then release
    wait_strobe_col(5'b11101, "t2_sync");
    keys[9] = 1'b1;
    base = pulses;
    repeat (40) tick();
    chk("t2_one_pulse", pulses - base, 1);
    chk("t2_keycode", keycode, 9);
    chk("t2_col_held", col, 5'b11011);
    wait_strobe_col(5'b11011, "t2_sync_rel");
    keys[9] = 1'b0;
    wait_strobe_col(5'b11011, "t2_rel1");
    wait_strobe_col(5'b11011, "t2_rel2");
    wait_strobe_col(5'b11011, "t2_rel3");
    tick();
    chk("t2_col_adv", col, 5'b10111);
    chk("t2_still_one", pulses - base, 1);

    // Bounce: two matching strobes then one open, three times
    wait_strobe_col(5'b11101, "t3_sync");
    keys[9] = 1'b1;
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      wait_strobe_col(5'b11011, "t3_m1");
      wait_strobe_col(5'b11011, "t3_m2");
      keys[9] = 1'b0;
      wait_strobe_col(5'b11011, "t3_open");
      keys[9] = (i < 2);
    end
    chk("t3_no_pulse", pulses - base, 0);
    wait_strobe_col(5'b01111, "t3_resume");
    chk("t3_keycode", keycode, 9);

    // Two rows low on col 0 is invalid; then a clean col 4 / row 3 press
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    base = pulses;
    repeat (40) tick();
    chk("t4_invalid_nopulse", pulses - base, 0);
    chk("t4_keycode_kept", keycode, 9);
    wait_strobe_col(5'b11101, "t4_scan_past");
    keys = 20'd0;
    keys[19] = 1'b1;
    wait_pulses(base + 1, "t4_pulse");
    chk("t4_keycode", keycode, 19);
    keys[19] = 1'b0;
    wait_strobe_col(5'b11110, "t4_resume");
    chk("t4_one_pulse", pulses - base, 1);

    // Reset after two matching strobes with the key kept down
    keys[6] = 1'b1;
    wait_strobe_col(5'b11101, "t5_m1");
    wait_strobe_col(5'b11101, "t5_m2");
    tick();
    base = pulses;
    reset = 1'b0;
    tick();
    tick();
    chk("t5_rst_newkey", newkey, 0);
    chk("t5_rst_col", col, 5'b11110);
    chk("t5_rst_keycode", keycode, 0);
    reset = 1'b1;
    wait_strobe_col(5'b11101, "t5_f1");
    wait_strobe_col(5'b11101, "t5_f2");
    wait_strobe_col(5'b11101, "t5_f3");
    chk("t5_no_early", newkey, 0);
    chk("t5_no_pulse_yet", pulses - base, 0);
    tick();
    chk("t5_pulse", newkey, 1);
    chk("t5_keycode", keycode, 6);
    tick();
    chk("t5_pulse_end", newkey, 0);
    chk("t5_one_pulse", pulses - base, 1);
    keys[6] = 1'b0;
    wait_strobe_col(5'b11011, "t5_resume");

    // Same key twice: col 0 / row 0
    keys[0] = 1'b1;
    base = pulses;
    wait_pulses(base + 1, "t6_pulse1");
    t1 = cyc;
    chk("t6_nk1", newkey, 1);
    chk("t6_keycode1", keycode, 0);
    tick();
    chk("t6_nk1_end", newkey, 0);
    keys[0] = 1'b0;
    wait_strobe_col(5'b11101, "t6_adv");
    keys[0] = 1'b1;
    wait_pulses(base + 2, "t6_pulse2");
    t2 = cyc;
    chk("t6_nk2", newkey, 1);
    chk("t6_keycode2", keycode, 0);
    chk("t6_spacing", {31'd0, (t2 - t1) >= 24}, 1);
    tick();
    chk("t6_nk2_end", newkey, 0);
    keys[0] = 1'b0;
    repeat (20) tick();
    chk("t6_two_pulses", pulses - base, 2);
    chk("pulse_width", wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad front end that drives the calculator's key inputs. It scans a 5-column × 4-row switch matrix and synchronises and debounces the row returns. For each accepted keypress it produces exactly one `newkey` pulse with a 5-bit `keycode`, feeding `Calculator.newkey` / `Calculator.keycode` directly.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven (dwell), ≥ 2.
- `DEBOUNCE`, default 16: consecutive matching row samples needed to accept a press or a release, ≥ 1.

Ports:
- `clock`  in  1  system clock; one clock.
- `reset`  in  1  reset is asynchronous and active-low.
- `row`  in  4  row returns, active-low (pulled up externally), asynchronous to `clock`.
- `col`  out  5  column drive, active-low one-hot.
- `newkey`  out  1  high for exactly one cycle per accepted press.
- `keycode`  out  5  `{col_index[2:0], row_index[1:0]}` of the last accepted key; values 0–19 only.

## Operation
- `row` passes through a 2-flop synchroniser; all logic uses the synchronised value `rs`.
- Dwell counter runs 0..SCAN_DIV-1 and wraps. The sample strobe fires on the cycle the counter equals SCAN_DIV-1; `rs` is evaluated only on strobe cycles.
- A sample is "single-key at r" if exactly one bit of `rs` is 0 (bit r). All-ones means "none". Two or more zeros means "invalid" and is treated as none.
- State machine:
  - **SCAN**
    - On strobe with none/invalid: advance column on the next cycle (0→1→2→3→4→0).
    - On strobe with single-key at r: latch candidate (current col, r), set match count = 1, go to DEBOUNCE. The column is not advanced.
  - **DEBOUNCE** (column held)
    - On strobe with single-key at the candidate row: increment count. If count reaches DEBOUNCE, go to HELD and assert the press outputs.
    - On strobe with anything else: clear count, go to SCAN, advance column.
    - With DEBOUNCE = 1, the press is accepted directly from SCAN on the first strobe.
  - **HELD** (column held)
    - On strobe with none: increment release count. Any other sample clears it.
    - When release count reaches DEBOUNCE: go to SCAN, advance column.
    - Further presses, other keys on the same column, and bounce generate no `newkey`.
- Press acceptance: `keycode` loads `{candidate_col, candidate_row}` and `newkey` = 1, both registered, in the cycle after the accepting strobe. `keycode` holds until the next accepted press.
- Keys on other columns are invisible while DEBOUNCE or HELD is active; no rollover.

## Timing
- Reset values: state SCAN, column index 0, `col` = 5'b11110, dwell counter 0, match/release counts 0, synchroniser flops 1, `newkey` = 0, `keycode` = 0.
- Reset mid-DEBOUNCE or mid-HELD aborts immediately. No `newkey` is emitted on or after reset release until a fresh full debounce completes.
- `col` changes on the cycle after a strobe (registered). A column is therefore driven for exactly SCAN_DIV cycles unless held.
- Press latency: `newkey` rises 1 cycle after the DEBOUNCE-th matching strobe. The first matching strobe can occur at the earliest 2 cycles (synchroniser) after `row` settles within the active column's dwell.
- `newkey` never asserts on two consecutive cycles. Minimum spacing between pulses is (2·DEBOUNCE)·SCAN_DIV cycles.
- Counters saturate at DEBOUNCE; no wrap.

## Test plan
Use SCAN_DIV = 4, DEBOUNCE = 3.
- Hold reset low 3 cycles → `col` = 11110, `newkey` = 0, `keycode` = 0. Release → `col` cycles 11110, 11101, 11011, 10111, 01111, each for 4 cycles.
- Press col 2 / row 1 (row = 1101 whenever `col` = 11011), held 40 cycles → exactly one `newkey` pulse with `keycode` = 9. `col` stays 11011 until release plus 3 empty strobes, then becomes 10111.
- Same key bouncing: row low for 2 strobes, high for 1, repeated → no `newkey`, scanning resumes.
- Rows 0 and 3 low together on col 0 → no `newkey`, `keycode` unchanged. Then a clean press of col 4 / row 3 → one pulse with `keycode` = 19.
- Assert reset after 2 matching strobes of a press, then release with the key still down → no pulse until 3 fresh matching strobes complete, then one pulse.
- Press, release, and press again the same key (col 0 / row 0) → two pulses with `keycode` = 0. Pulses are ≥ 24 cycles apart and each is 1 cycle wide.
